// File: rtl/celda_tipica_pkg.sv
// Shared state encoding and next-state function for the iterative magnitude comparator cell.
package celda_tipica_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    STATE_EQ = 2'b01,
    STATE_GT = 2'b10,
    STATE_LT = 2'b11
  } state_e;

  // GT and LT are absorbing; EQ and the illegal 00 code both resolve on the bit pair.
  function automatic state_e next_state(input logic [STATE_W-1:0] st,
                                        input logic a,
                                        input logic b);
    state_e r;
    r = STATE_EQ;
    if (st == STATE_GT) begin
      r = STATE_GT;
    end else if (st == STATE_LT) begin
      r = STATE_LT;
    end else begin
      case ({a, b})
        2'b01:   r = STATE_LT;
        2'b10:   r = STATE_GT;
        default: r = STATE_EQ;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/celda_tipica_ns.sv
// Purely combinational next-state logic of one comparator cell.
module celda_tipica_ns
  import celda_tipica_pkg::*;
(
  input  logic [STATE_W-1:0] st_i,
  input  logic               a_i,
  input  logic               b_i,
  output logic [STATE_W-1:0] nst_o
);

  assign nst_o = next_state(st_i, a_i, b_i);

endmodule

// File: rtl/celda_tipica.sv
// Comparator cell: reset-free chained next-state path plus a bit-serial state register
// that reuses the same next-state logic to compare words one bit per clock, MSB first.
module celda_tipica
  import celda_tipica_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               p,
  input  logic               q,
  input  logic               Ai,
  input  logic               Bi,
  output logic               P,
  output logic               Q,
  input  logic               ser_start,
  input  logic               ser_en,
  output logic [STATE_W-1:0] ser_st,
  output logic               eq,
  output logic               gt,
  output logic               lt
);

  logic [STATE_W-1:0] chain_nst;
  logic [STATE_W-1:0] ser_base;
  logic [STATE_W-1:0] ser_nst;
  state_e             ser_st_q;
  state_e             ser_st_d;

  celda_tipica_ns u_ns_chain (
    .st_i  ({p, q}),
    .a_i   (Ai),
    .b_i   (Bi),
    .nst_o (chain_nst)
  );

  assign P = chain_nst[1];
  assign Q = chain_nst[0];

  // A start evaluates from EQ, so prior history is discarded even when ser_en is also high.
  assign ser_base = ser_start ? STATE_EQ : ser_st_q;

  celda_tipica_ns u_ns_ser (
    .st_i  (ser_base),
    .a_i   (Ai),
    .b_i   (Bi),
    .nst_o (ser_nst)
  );

  always_comb begin
    ser_st_d = ser_st_q;
    if (ser_start || ser_en) begin
      ser_st_d = state_e'(ser_nst);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ser_st_q <= STATE_EQ;
    end else begin
      ser_st_q <= ser_st_d;
    end
  end

  assign ser_st = ser_st_q;
  assign eq     = (ser_st_q == STATE_EQ);
  assign gt     = (ser_st_q == STATE_GT);
  assign lt     = (ser_st_q == STATE_LT);

endmodule

// File: tb/tb_celda_tipica.sv
// Scoreboard bench for celda_tipica: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_celda_tipica;

  logic       clk;
  logic       rst_n;
  logic       p, q, Ai, Bi;
  logic       P, Q;
  logic       ser_start, ser_en;
  logic [1:0] ser_st;
  logic       eq, gt, lt;

  int unsigned checks;
  int unsigned failures;

  typedef struct {
    string      name;
    bit         is_comb;
    logic [1:0] exp;
  } exp_t;

  exp_t sb[$];

  celda_tipica dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p         (p),
    .q         (q),
    .Ai        (Ai),
    .Bi        (Bi),
    .P         (P),
    .Q         (Q),
    .ser_start (ser_start),
    .ser_en    (ser_en),
    .ser_st    (ser_st),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: compares every pending expectation on the falling edge.
  always @(negedge clk) begin
    exp_t       it;
    logic [2:0] flags;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      if (it.is_comb) begin
        checks++;
        if ({P, Q} !== it.exp) begin
          failures++;
          $display("FAIL %s: PQ got %b required %b", it.name, {P, Q}, it.exp);
        end
      end else begin
        case (it.exp)
          2'b01:   flags = 3'b100;
          2'b10:   flags = 3'b010;
          2'b11:   flags = 3'b001;
          default: flags = 3'b000;
        endcase
        checks++;
        if (ser_st !== it.exp) begin
          failures++;
          $display("FAIL %s: ser_st got %b required %b", it.name, ser_st, it.exp);
        end
        checks++;
        if ({eq, gt, lt} !== flags) begin
          failures++;
          $display("FAIL %s_flags: eq/gt/lt got %b required %b", it.name, {eq, gt, lt}, flags);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input bit c, input logic [1:0] e);
    exp_t it;
    it.name    = n;
    it.is_comb = c;
    it.exp     = e;
    sb.push_back(it);
  endtask

  // One serial word, MSB first; exp[i] is the state after bit i is clocked.
  task automatic ser_word(input string n, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] e3, input logic [1:0] e2,
                          input logic [1:0] e1, input logic [1:0] e0);
    logic [1:0] ex [4];
    ex[3] = e3; ex[2] = e2; ex[1] = e1; ex[0] = e0;
    for (int i = 3; i >= 0; i--) begin
      Ai        = a[i];
      Bi        = b[i];
      ser_start = (i == 3);
      ser_en    = (i != 3);
      step();
      push($sformatf("%s_bit%0d", n, i), 1'b0, ex[i]);
    end
    ser_start = 1'b0;
    ser_en    = 1'b0;
  endtask

  logic [1:0] row_eq [4];
  logic [1:0] pq_list [4];
  logic [1:0] pq;
  logic [1:0] ab;

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    p         = 1'b0;
    q         = 1'b0;
    Ai        = 1'b0;
    Bi        = 1'b0;
    ser_start = 1'b0;
    ser_en    = 1'b0;

    row_eq[0] = 2'b01; row_eq[1] = 2'b11; row_eq[2] = 2'b10; row_eq[3] = 2'b01;
    pq_list[0] = 2'b01; pq_list[1] = 2'b10; pq_list[2] = 2'b11; pq_list[3] = 2'b00;

    step();
    step();
    push("reset", 1'b0, 2'b01);

    // Chained path works with reset still asserted.
    {p, q} = 2'b01; Ai = 1'b0; Bi = 1'b1;
    #1;
    push("comb_in_reset", 1'b1, 2'b11);
    step();
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      pq = pq_list[k];
      for (int j = 0; j < 4; j++) begin
        ab     = j[1:0];
        {p, q} = pq;
        Ai     = ab[1];
        Bi     = ab[0];
        #1;
        if (pq == 2'b10)      push($sformatf("chain_gt_ab%b", ab), 1'b1, 2'b10);
        else if (pq == 2'b11) push($sformatf("chain_lt_ab%b", ab), 1'b1, 2'b11);
        else                  push($sformatf("chain_pq%b_ab%b", pq, ab), 1'b1, row_eq[j]);
        step();
      end
    end
    {p, q} = 2'b00;

    ser_word("w1011_1001", 4'b1011, 4'b1001, 2'b01, 2'b01, 2'b10, 2'b10);
    ser_word("w0110_0110", 4'b0110, 4'b0110, 2'b01, 2'b01, 2'b01, 2'b01);
    ser_word("w0100_0110", 4'b0100, 4'b0110, 2'b01, 2'b01, 2'b11, 2'b11);

    Ai = 1'b1; Bi = 1'b0;
    step();
    push("hold_lt", 1'b0, 2'b11);

    ser_en = 1'b1;
    rst_n  = 1'b0;
    step();
    push("reset_mid_word", 1'b0, 2'b01);
    rst_n  = 1'b1;
    ser_en = 1'b0;

    // From LT history: start+enable with AB=10 must go through EQ to GT.
    ser_start = 1'b1; Ai = 1'b0; Bi = 1'b1;
    step();
    push("start_lt", 1'b0, 2'b11);
    ser_en = 1'b1; Ai = 1'b1; Bi = 1'b0;
    step();
    push("restart_from_lt", 1'b0, 2'b10);
    step();
    push("restart_from_gt", 1'b0, 2'b10);
    Ai = 1'b0; Bi = 1'b1;
    step();
    push("restart_gt_to_lt", 1'b0, 2'b11);
    Ai = 1'b1; Bi = 1'b1;
    step();
    push("restart_lt_to_eq", 1'b0, 2'b01);
    ser_start = 1'b0;
    ser_en    = 1'b0;

    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: pending got %0d required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
